// File: rtl/ladybird_serial_loader.sv
// rtl/ladybird_serial_loader.sv - framed boot image loader from UART read port to memory writes
module ladybird_serial_loader #(
  parameter logic [7:0] MAGIC  = 8'hA5,
  parameter int         ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ser_req,
  input  logic              ser_gnt,
  input  logic              ser_data_gnt,
  input  logic [7:0]        ser_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] entry_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              pending;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift;
  logic [31:0]       count;
  logic [ADDR_W-1:0] base;

  // A byte only counts once its read has been accepted; data_gnt outside that window is noise.
  logic        byte_valid;
  logic        last_byte;
  logic [31:0] assembled;
  assign byte_valid = pending & ser_data_gnt;
  assign last_byte  = (byte_cnt == 2'd3);
  assign assembled  = {ser_rdata, shift[31:8]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next = state;
    ser_req    = 1'b0;
    mem_req    = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_HUNT;
      end
      S_HUNT: begin
        ser_req = ~pending;
        if (byte_valid && ser_rdata == MAGIC) state_next = S_ADDR;
      end
      S_ADDR: begin
        ser_req = ~pending;
        if (byte_valid && last_byte) state_next = S_LEN;
      end
      S_LEN: begin
        ser_req = ~pending;
        if (byte_valid && last_byte) state_next = (assembled == 32'd0) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        ser_req = ~pending;
        if (byte_valid && last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_req = 1'b1;
        if (mem_gnt) state_next = (count == 32'd1) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign mem_wstrb = mem_req ? 4'hF : 4'h0;

  // Single-outstanding read tracker: set on accepted request, cleared on data delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (ser_req && ser_gnt) begin
      pending <= 1'b1;
    end else if (byte_valid) begin
      pending <= 1'b0;
    end
  end

  // Byte assembly, header capture and write address/data progression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt   <= 2'd0;
      shift      <= 32'd0;
      count      <= 32'd0;
      base       <= '0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      entry_addr <= '0;
    end else begin
      if (byte_valid && (state == S_ADDR || state == S_LEN || state == S_DATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= assembled;
        if (last_byte) begin
          case (state)
            S_ADDR: base <= {assembled[ADDR_W-1:2], 2'b00};
            S_LEN: begin
              count    <= assembled;
              mem_addr <= base;
            end
            S_DATA:  mem_wdata <= assembled;
            default: ;
          endcase
        end
      end
      if (state == S_WRITE && mem_gnt) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        count    <= count - 32'd1;
      end
      // Capture on entry to DONE so entry_addr is already valid alongside the done pulse.
      if (state != S_DONE && state_next == S_DONE) entry_addr <= base;
    end
  end

endmodule

// File: tb/tb_ladybird_serial_loader.sv
// tb/tb_ladybird_serial_loader.sv - directed self-checking bench for ladybird_serial_loader
module tb_ladybird_serial_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ser_req;
  logic        ser_gnt;
  logic        ser_data_gnt;
  logic [7:0]  ser_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        busy;
  logic        done;
  logic [31:0] entry_addr;

  int nvec = 0;
  int nerr = 0;

  ladybird_serial_loader #(.MAGIC(8'hA5), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ser_req(ser_req), .ser_gnt(ser_gnt), .ser_data_gnt(ser_data_gnt), .ser_rdata(ser_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .busy(busy), .done(done), .entry_addr(entry_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Serve one serial read: grant, optional spurious data_gnt in the grant cycle, then data after dly cycles.
  task automatic send_byte(input logic [7:0] b, input int dly, input bit spur);
    int n = 0;
    while (ser_req !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("ser_req_wait", {31'd0, ser_req}, 32'd1);
    ser_gnt = 1'b1;
    if (spur) begin
      ser_data_gnt = 1'b1;
      ser_rdata    = ~b;
    end
    @(negedge clk);
    ser_gnt      = 1'b0;
    ser_data_gnt = 1'b0;
    check("ser_req_drop", {31'd0, ser_req}, 32'd0);
    repeat (dly) begin
      @(negedge clk);
      check("one_outstanding", {31'd0, ser_req}, 32'd0);
    end
    ser_data_gnt = 1'b1;
    ser_rdata    = b;
    @(negedge clk);
    ser_data_gnt = 1'b0;
    ser_rdata    = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int dly, input bit spur);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0], dly, spur);
      v = v >> 8;
    end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input int stall);
    check("mem_req_latency", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, a);
    check("mem_wdata", mem_wdata, d);
    check("mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    check("no_ser_req_write", {31'd0, ser_req}, 32'd0);
    repeat (stall) begin
      @(negedge clk);
      check("stall_mem_req", {31'd0, mem_req}, 32'd1);
      check("stall_mem_addr", mem_addr, a);
      check("stall_mem_wdata", mem_wdata, d);
      check("stall_no_ser_req", {31'd0, ser_req}, 32'd0);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("mem_wstrb_idle", {28'd0, mem_wstrb}, 32'h0);
  endtask

  task automatic expect_done(input logic [31:0] e);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("entry_addr", entry_addr, e);
    check("done_no_mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("done_single", {31'd0, done}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("entry_hold", entry_addr, e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_armed", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ser_gnt = 1'b0; ser_data_gnt = 1'b0;
    ser_rdata = 8'h00; mem_gnt = 1'b0;
    #1;
    check("rst_ser_req", {31'd0, ser_req}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_entry", entry_addr, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ser_req", {31'd0, ser_req}, 32'd0);

    // Basic two-word load at 0x1000.
    do_start();
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'h0000_1000, 0, 1'b0);
    send_word(32'h0000_0002, 0, 1'b0);
    send_word(32'h4433_2211, 0, 1'b0);
    expect_write(32'h0000_1000, 32'h4433_2211, 0);
    send_word(32'h8877_6655, 0, 1'b0);
    expect_write(32'h0000_1004, 32'h8877_6655, 0);
    expect_done(32'h0000_1000);

    // Resync past garbage, slow serial data and spurious data_gnt in the acceptance cycle.
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    send_byte(8'h5A, 0, 1'b0);
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'h0000_2000, 0, 1'b0);
    send_word(32'h0000_0001, 0, 1'b0);
    send_word(32'hDEAD_BEEF, 20, 1'b1);
    expect_write(32'h0000_2000, 32'hDEAD_BEEF, 0);
    expect_done(32'h0000_2000);

    // Zero-length frame with misaligned base.
    do_start();
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'h0000_3003, 0, 1'b0);
    send_word(32'h0000_0000, 0, 1'b0);
    expect_done(32'h0000_3000);

    // Address wrap with memory backpressure on the first word.
    do_start();
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'hFFFF_FFFC, 0, 1'b0);
    send_word(32'h0000_0002, 0, 1'b0);
    send_word(32'h0123_4567, 0, 1'b0);
    expect_write(32'hFFFF_FFFC, 32'h0123_4567, 7);
    send_word(32'h89AB_CDEF, 0, 1'b0);
    expect_write(32'h0000_0000, 32'h89AB_CDEF, 0);
    expect_done(32'hFFFF_FFFC);

    // Asynchronous reset while a payload read is outstanding.
    do_start();
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'h0000_4000, 0, 1'b0);
    send_word(32'h0000_0001, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    check("pre_rst_ser_req", {31'd0, ser_req}, 32'd1);
    ser_gnt = 1'b1;
    @(negedge clk);
    ser_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ser_req", {31'd0, ser_req}, 32'd0);
    check("arst_mem_req", {31'd0, mem_req}, 32'd0);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    check("arst_entry", entry_addr, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Late data for the abandoned read must be ignored.
    ser_data_gnt = 1'b1;
    ser_rdata    = 8'h33;
    @(negedge clk);
    ser_data_gnt = 1'b0;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Clean reload after reset.
    do_start();
    send_byte(8'hA5, 0, 1'b0);
    send_word(32'h0000_5000, 0, 1'b0);
    send_word(32'h0000_0001, 0, 1'b0);
    send_word(32'hF0DE_BC9A, 3, 1'b0);
    expect_write(32'h0000_5000, 32'hF0DE_BC9A, 0);
    expect_done(32'h0000_5000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
